// File: rtl/seq_divider_u8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, high), start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero.
module seq_divider_u8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  // dvd shifts dividend bits out of the top and quotient bits in at
  // the bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvd_n;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dsr_n;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] rem_n;
  logic             dbz_n;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // The restored remainder is always below the divisor, so it fits in
  // WIDTH bits; only the shifted value needs the extra top bit. The
  // WIDTH-bit subtract is exact whenever ge holds.
  always_comb begin
    shifted = {acc, dvd[WIDTH-1]};
    ge      = shifted >= {1'b0, dsr};
    diff    = shifted[WIDTH-1:0] - dsr;
  end

  always_comb begin
    state_n = state;
    dvd_n   = dvd;
    dsr_n   = dsr;
    acc_n   = acc;
    cnt_n   = cnt;
    quo_n   = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;
    unique case (state)
      IDLE: begin
        if (start) begin
          dvd_n = dividend;
          dsr_n = divisor;
          acc_n = '0;
          cnt_n = CW'(WIDTH - 1);
          if (divisor == '0) begin
            state_n = DONE;
            quo_n   = '1;
            rem_n   = dividend;
            dbz_n   = 1'b1;
          end else begin
            state_n = CALC;
          end
        end
      end
      CALC: begin
        dvd_n = {dvd[WIDTH-2:0], ge};
        acc_n = ge ? diff : shifted[WIDTH-1:0];
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          state_n = DONE;
          quo_n   = dvd_n;
          rem_n   = acc_n;
          dbz_n   = 1'b0;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      acc         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      dvd         <= dvd_n;
      dsr         <= dsr_n;
      acc         <= acc_n;
      cnt         <= cnt_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider_u8.sv
// Self-checking bench for seq_divider_u8: directed vector table,
// handshake corner cases and a randomized back-to-back run.
module tb_seq_divider_u8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_u8 #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  vec_t tbl[8];
  op_t  ops[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z);
    if (b == 8'd0) begin
      q = 8'd255;
      r = a;
      z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int lat, output int bcnt);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q, r, eq, er;
    logic       z, ez;
    int         lat, bcnt, nd, cyc, last;
    op_t        op;

    tbl[0] = '{8'd200, 8'd7,   8'd28,  8'd4, 1'b0, 9};
    tbl[1] = '{8'd5,   8'd0,   8'd255, 8'd5, 1'b1, 1};
    tbl[2] = '{8'd9,   8'd4,   8'd2,   8'd1, 1'b0, 9};
    tbl[3] = '{8'd255, 8'd1,   8'd255, 8'd0, 1'b0, 9};
    tbl[4] = '{8'd255, 8'd255, 8'd1,   8'd0, 1'b0, 9};
    tbl[5] = '{8'd3,   8'd10,  8'd0,   8'd3, 1'b0, 9};
    tbl[6] = '{8'd0,   8'd9,   8'd0,   8'd0, 1'b0, 9};
    tbl[7] = '{8'd0,   8'd0,   8'd255, 8'd0, 1'b1, 1};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, q, r, z, lat, bcnt);
      chk($sformatf("vec%0d_q", i), int'(q), int'(tbl[i].q));
      chk($sformatf("vec%0d_r", i), int'(r), int'(tbl[i].r));
      chk($sformatf("vec%0d_dbz", i), int'(z), int'(tbl[i].z));
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_busy", i), bcnt, tbl[i].lat);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), int'(done), 0);
      chk($sformatf("vec%0d_idle", i), int'(busy), 0);
    end

    // start pulses while busy must be ignored
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd6;
    start    = 1'b1;
    nd = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start    = (k >= 2 && k <= 7);
      dividend = 8'd100;
      divisor  = 8'd3;
      if (done) begin
        nd++;
        q = quotient;
        r = remainder;
      end
    end
    start = 1'b0;
    chk("busy_ign_ndone", nd, 1);
    chk("busy_ign_q", int'(q), 8);
    chk("busy_ign_r", int'(r), 2);
    chk("busy_ign_hold_q", int'(quotient), 8);

    // reset in the middle of CALC aborts the op
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_dbz", int'(div_by_zero), 0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_op(8'd17, 8'd5, q, r, z, lat, bcnt);
    chk("post_abort_q", int'(q), 3);
    chk("post_abort_r", int'(r), 2);
    chk("post_abort_lat", lat, 9);

    // randomized back-to-back run with start held high
    @(negedge clk);
    op.a = 8'($urandom_range(0, 255));
    op.b = 8'($urandom_range(1, 255));
    dividend = op.a;
    divisor  = op.b;
    ops.push_back(op);
    start = 1'b1;
    nd   = 0;
    cyc  = 0;
    last = -1;
    for (int c = 0; c < 12000 && nd < 1000; c++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (ops.size() == 0) begin
          chk("rand_queue", 0, 1);
        end else begin
          op = ops.pop_front();
          ref_div(op.a, op.b, eq, er, ez);
          chk($sformatf("rand%0d_q_%0d/%0d", nd, op.a, op.b),
              int'(quotient), int'(eq));
          chk($sformatf("rand%0d_r_%0d/%0d", nd, op.a, op.b),
              int'(remainder), int'(er));
          chk($sformatf("rand%0d_dbz", nd), int'(div_by_zero), int'(ez));
        end
        if (last >= 0) chk($sformatf("rand%0d_spacing", nd), cyc - last, 10);
        last = cyc;
        nd++;
        if (nd < 1000) begin
          op.a = 8'($urandom_range(0, 255));
          op.b = 8'($urandom_range(1, 255));
          dividend = op.a;
          divisor  = op.b;
          ops.push_back(op);
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        // operands in flight are latched; scribble on the inputs
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
    end
    start = 1'b0;
    chk("rand_count", nd, 1000);
    repeat (3) @(negedge clk);
    chk("rand_final_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
